// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared ids, types and widths for the vector memory arbiter
package vec_mem_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int XLEN_DEF  = 32;

  localparam int REQ_LSU_LD = 0;
  localparam int REQ_LSU_ST = 1;
  localparam int REQ_SCALAR = 2;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic                    we;
    logic [XLEN_DEF-1:0]     addr;
    logic [XLEN_DEF-1:0]     wdata;
    logic [XLEN_DEF/8-1:0]   be;
  } mem_beat_t;

endpackage

// File: rtl/vec_id_fifo.sv
// rtl/vec_id_fifo.sv - in-order FIFO of requester ids for outstanding reads
module vec_id_fifo
  import vec_mem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = req_id_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Push and pop together leave the occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vec_mem_arbiter.sv
// rtl/vec_mem_arbiter.sv - round-robin main-memory arbiter with burst lock
// and in-order read response routing.
module vec_mem_arbiter
  import vec_mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int N_REQ    = 3,
  parameter int RD_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*XLEN-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0]   req_wdata,
  input  logic [N_REQ*XLEN/8-1:0] req_be,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [XLEN/8-1:0]       mem_be,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = XLEN / 8;

  typedef logic [IDW-1:0] id_t;

  id_t  rr_ptr_q, rr_ptr_d;
  id_t  owner_q, owner_d;
  logic lock_q, lock_d;
  logic err_q, err_d;
  id_t  win, cand, head_id;
  logic win_found, issue, accept, push, pop;
  logic fifo_full, fifo_empty;

  // Lowest k wins, so the loop walks downward and the last hit sticks.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    if (lock_q) begin
      win       = owner_q;
      win_found = req_valid[owner_q];
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        cand = id_t'((int'(rr_ptr_q) + k) % N_REQ);
        if (req_valid[cand]) begin
          win       = cand;
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue     = ~rst & win_found & (req_we[win] | ~fifo_full);
    accept    = issue & mem_ready;
    push      = accept & ~req_we[win];
    pop       = ~rst & mem_rvalid & ~fifo_empty;
    mem_req   = issue;
    mem_we    = issue & req_we[win];
    mem_addr  = issue ? req_addr[int'(win)*XLEN +: XLEN] : '0;
    mem_wdata = issue ? req_wdata[int'(win)*XLEN +: XLEN] : '0;
    mem_be    = issue ? req_be[int'(win)*BW +: BW] : '0;
    req_ready = accept ? (N_REQ'(1) << win) : '0;
    rsp_valid = pop ? (N_REQ'(1) << head_id) : '0;
    rsp_data  = (~rst & mem_rvalid) ? mem_rdata : '0;
    err       = err_q & ~rst;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    owner_d  = owner_q;
    err_d    = err_q | (mem_rvalid & fifo_empty);
    if (accept) begin
      rr_ptr_d = win;
      lock_d   = ~req_last[win];
      if (!req_last[win]) begin
        owner_d = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= id_t'(N_REQ - 1);
      owner_q  <= id_t'(REQ_LSU_LD);
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  vec_id_fifo #(
    .DEPTH (RD_DEPTH),
    .T     (id_t)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (win),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// tb/tb_vec_mem_arbiter.sv - directed bench for vec_mem_arbiter
module tb_vec_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid, req_we, req_last;
  logic [95:0] req_addr, req_wdata;
  logic [11:0] req_be;
  logic [2:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  int vectors = 0;
  int fails   = 0;

  logic        s_rst;
  logic [2:0]  s_valid, s_ready, s_we, s_last;
  logic [95:0] s_addr, s_wdata;
  logic [11:0] s_be;

  vec_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic last,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req_valid[i]        = v;
    req_we[i]           = we;
    req_last[i]         = last;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_be[i*4 +: 4]      = b;
  endtask

  task automatic clear_inputs();
    req_valid  = '0; req_we = '0; req_last = '0;
    req_addr   = '0; req_wdata = '0; req_be = '0;
    mem_ready  = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Requesters stalled last cycle must present the same beat this cycle.
  task automatic nxt();
    for (int i = 0; i < 3; i++) begin
      if (!s_rst && !rst && s_valid[i] && !s_ready[i] && req_valid[i]) begin
        chk($sformatf("hold_addr%0d", i), req_addr[i*32 +: 32], s_addr[i*32 +: 32]);
        chk($sformatf("hold_wdata%0d", i), req_wdata[i*32 +: 32], s_wdata[i*32 +: 32]);
        chk($sformatf("hold_ctl%0d", i), {req_we[i], req_last[i], req_be[i*4 +: 4]},
            {s_we[i], s_last[i], s_be[i*4 +: 4]});
      end
    end
    s_rst = rst; s_valid = req_valid; s_ready = req_ready; s_we = req_we;
    s_last = req_last; s_addr = req_addr; s_wdata = req_wdata; s_be = req_be;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    mid();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    s_rst = 1'b1; s_valid = '0; s_ready = '0; s_we = '0; s_last = '0;
    s_addr = '0; s_wdata = '0; s_be = '0;
    rst = 1'b1;
    clear_inputs();
    #1;

    // Reset with live inputs: every output held low.
    set_req(0, 1, 0, 1, 32'h10, 0, 4'hF);
    set_req(1, 1, 0, 1, 32'h20, 0, 4'hF);
    set_req(2, 1, 0, 1, 32'h30, 0, 4'hF);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    mid();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    nxt();
    rst = 1'b0;

    // Test 1: three readers, round robin until the id FIFO fills.
    mid(); chk("t1_c1_ready", req_ready, 3'b001); chk("t1_c1_addr", mem_addr, 32'h10); nxt();
    mid(); chk("t1_c2_ready", req_ready, 3'b010); chk("t1_c2_addr", mem_addr, 32'h20); nxt();
    mid(); chk("t1_c3_ready", req_ready, 3'b100); chk("t1_c3_addr", mem_addr, 32'h30); nxt();
    mid(); chk("t1_c4_ready", req_ready, 3'b001); nxt();
    mid(); chk("t1_full_mem_req", mem_req, 0); chk("t1_full_ready", req_ready, 0);
    chk("t1_full_addr", mem_addr, 0); nxt();

    // Test 4: pop and blocked read in the same cycle, read accepted next cycle.
    mem_rvalid = 1'b1; mem_rdata = 32'hA1;
    mid(); chk("t4_rsp_valid", rsp_valid, 3'b001); chk("t4_rsp_data", rsp_data, 32'hA1);
    chk("t4_blocked_req", mem_req, 0); chk("t4_blocked_ready", req_ready, 0); nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    mid(); chk("t4_next_ready", req_ready, 3'b010); chk("t4_next_addr", mem_addr, 32'h20);
    chk("t4_rsp_idle", rsp_valid, 0); chk("t4_rsp_data_idle", rsp_data, 0); nxt();
    do_reset();

    // Test 2: locked write burst from requester 1.
    mem_ready = 1'b1;
    set_req(0, 1, 0, 1, 32'h40, 0, 4'hF);
    mid(); chk("t2_pre_ready", req_ready, 3'b001); nxt();
    set_req(1, 1, 1, 0, 32'h300, 32'h11, 4'h3);
    set_req(2, 1, 0, 1, 32'h50, 0, 4'hF);
    mid(); chk("t2_b1_ready", req_ready, 3'b010); chk("t2_b1_we", mem_we, 1);
    chk("t2_b1_addr", mem_addr, 32'h300); chk("t2_b1_wdata", mem_wdata, 32'h11);
    chk("t2_b1_be", mem_be, 4'h3); nxt();
    set_req(1, 1, 1, 0, 32'h304, 32'h22, 4'h3);
    mid(); chk("t2_b2_ready", req_ready, 3'b010); chk("t2_b2_addr", mem_addr, 32'h304); nxt();
    req_valid[1] = 1'b0;
    mid(); chk("t2_idle_req", mem_req, 0); chk("t2_idle_ready", req_ready, 0); nxt();
    set_req(1, 1, 1, 1, 32'h308, 32'h33, 4'h3);
    mid(); chk("t2_b3_ready", req_ready, 3'b010); chk("t2_b3_wdata", mem_wdata, 32'h33); nxt();
    req_valid[1] = 1'b0;
    mid(); chk("t2_after_ready", req_ready, 3'b100); chk("t2_after_addr", mem_addr, 32'h50);
    chk("t2_after_we", mem_we, 0); nxt();
    do_reset();

    // Test 3: responses routed back in issue order.
    mem_ready = 1'b1;
    set_req(0, 1, 0, 1, 32'h100, 0, 4'hF);
    mid(); chk("t3_r0_ready", req_ready, 3'b001); nxt();
    req_valid[0] = 1'b0;
    set_req(2, 1, 0, 1, 32'h200, 0, 4'hF);
    mid(); chk("t3_r2_ready", req_ready, 3'b100); chk("t3_r2_addr", mem_addr, 32'h200); nxt();
    req_valid[2] = 1'b0;
    set_req(0, 1, 0, 1, 32'h104, 0, 4'hF);
    mid(); chk("t3_r0b_ready", req_ready, 3'b001); chk("t3_r0b_addr", mem_addr, 32'h104); nxt();
    req_valid[0] = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA;
    mid(); chk("t3_rsp1_v", rsp_valid, 3'b001); chk("t3_rsp1_d", rsp_data, 32'hA); nxt();
    mem_rdata = 32'hB;
    mid(); chk("t3_rsp2_v", rsp_valid, 3'b100); chk("t3_rsp2_d", rsp_data, 32'hB); nxt();
    mem_rdata = 32'hC;
    mid(); chk("t3_rsp3_v", rsp_valid, 3'b001); chk("t3_rsp3_d", rsp_data, 32'hC); nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    mid(); chk("t3_rsp_idle", rsp_valid, 0); chk("t3_err", err, 0); nxt();
    do_reset();

    // Test 5: memory back-pressure holds the issued beat.
    set_req(0, 1, 0, 1, 32'h500, 0, 4'hF);
    for (int c = 0; c < 3; c++) begin
      mid(); chk("t5_stall_req", mem_req, 1); chk("t5_stall_addr", mem_addr, 32'h500);
      chk("t5_stall_ready", req_ready, 0); nxt();
    end
    mem_ready = 1'b1;
    set_req(2, 1, 0, 1, 32'h5F0, 0, 4'hF);
    mid(); chk("t5_accept_ready", req_ready, 3'b001); nxt();
    req_valid[0] = 1'b0;
    mid(); chk("t5_ptr_ready", req_ready, 3'b100); nxt();
    do_reset();

    // Test 6: reset drops outstanding reads and the lock.
    mem_ready = 1'b1;
    set_req(0, 1, 0, 0, 32'h600, 0, 4'hF);
    set_req(2, 1, 0, 1, 32'h700, 0, 4'hF);
    mid(); chk("t6_c1_ready", req_ready, 3'b001); nxt();
    set_req(0, 1, 0, 0, 32'h604, 0, 4'hF);
    mid(); chk("t6_c2_locked", req_ready, 3'b001); chk("t6_c2_addr", mem_addr, 32'h604); nxt();
    rst = 1'b1;
    mid(); chk("t6_rst_req", mem_req, 0); nxt();
    rst = 1'b0;
    set_req(0, 1, 0, 1, 32'h608, 0, 4'hF);
    mem_rvalid = 1'b1; mem_rdata = 32'hDD;
    mid(); chk("t6_post_ready", req_ready, 3'b001); chk("t6_post_rsp", rsp_valid, 0);
    chk("t6_post_err0", err, 0); nxt();
    req_valid[0] = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    mid(); chk("t6_err_set", err, 1); chk("t6_rr_ready", req_ready, 3'b100); nxt();
    req_valid[2] = 1'b0;
    mid(); chk("t6_err_sticky", err, 1); nxt();
    do_reset();
    mid(); chk("t6_err_cleared", err, 0); nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
